// File: rtl/alu_pkg.sv
// Shared types for alu_mdu_seq: SEL encodings, iterative-unit FSM states and
// the filler pattern returned for unsupported operation codes.
package alu_pkg;

  typedef enum logic [4:0] {
    SEL_ADD    = 5'b00000,
    SEL_SLL    = 5'b00001,
    SEL_SLT    = 5'b00010,
    SEL_SLTU   = 5'b00011,
    SEL_XOR    = 5'b00100,
    SEL_SRL    = 5'b00101,
    SEL_OR     = 5'b00110,
    SEL_AND    = 5'b00111,
    SEL_SUB    = 5'b01000,
    SEL_LUI    = 5'b01001,
    SEL_SRA    = 5'b01101,
    SEL_MUL    = 5'b10000,
    SEL_MULH   = 5'b10001,
    SEL_MULHSU = 5'b10010,
    SEL_MULHU  = 5'b10011,
    SEL_DIV    = 5'b10100,
    SEL_DIVU   = 5'b10101,
    SEL_REM    = 5'b10110,
    SEL_REMU   = 5'b10111
  } alu_sel_t;

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} mdu_state_t;

  localparam logic [31:0] ALU_BAD_PATTERN = 32'hDEADBEEF;

endpackage

// File: rtl/iter_muldiv.sv
// Radix-2 iterative multiply / restoring divide on a 2*WIDTH accumulator.
// Works on operand magnitudes; res applies sign correction once iteration ends.
module iter_muldiv import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res
);
  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc, mul_nxt, div_nxt, prod;
  logic [WIDTH-1:0]   mb, ma_in, mb_in, quo, rem;
  logic [WIDTH:0]     sum, r_sh, r_sub;
  logic [CW-1:0]      count;
  logic [1:0]         fn;
  logic               run, is_div, neg_q, neg_r, a_sgn, b_sgn, sa, sb, ge;

  // funct3: MULH/MULHSU sign op1, MULH signs op2; DIV/REM sign both
  assign a_sgn = op[2] ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
  assign b_sgn = op[2] ? ~op[0] : (op[1:0] == 2'b01);
  assign sa    = a_sgn & a[WIDTH-1];
  assign sb    = b_sgn & b[WIDTH-1];
  assign ma_in = sa ? -a : a;
  assign mb_in = sb ? -b : b;

  assign sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mb} : '0);
  assign mul_nxt = {sum, acc[WIDTH-1:1]};

  assign r_sh    = acc[2*WIDTH-1:WIDTH-1];
  assign ge      = r_sh >= {1'b0, mb};
  assign r_sub   = r_sh - {1'b0, mb};
  assign div_nxt = ge ? {r_sub[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                      : {r_sh[WIDTH-1:0],  acc[WIDTH-2:0], 1'b0};

  assign done = run && (count == CW'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0; mb <= '0; count <= '0; fn <= '0;
      run <= 1'b0; is_div <= 1'b0; neg_q <= 1'b0; neg_r <= 1'b0;
    end else if (start) begin
      acc    <= {{WIDTH{1'b0}}, ma_in};
      mb     <= mb_in;
      count  <= '0;
      fn     <= op[1:0];
      is_div <= op[2];
      neg_q  <= sa ^ sb;
      neg_r  <= sa;
      run    <= 1'b1;
    end else if (run) begin
      acc   <= is_div ? div_nxt : mul_nxt;
      count <= count + 1'b1;
      if (done) run <= 1'b0;
    end
  end

  // remainder follows the dividend's sign; quotient/product the sign xor
  assign prod = neg_q ? -acc : acc;
  assign quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  assign res  = is_div ? (fn[1] ? rem : quo)
                       : ((fn == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH]);

endmodule

// File: rtl/alu_mdu_seq.sv
// Registered RV32I ALU with optional iterative RV32M unit behind a valid/ready
// handshake. Define ALU_MDU_EN to build the multiply/divide datapath.
module alu_mdu_seq import alu_pkg::*; #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [4:0]       SEL,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);
  mdu_state_t         state, nxt_state;
  alu_sel_t           sel;
  logic [WIDTH-1:0]   bad, base_res, nxt_result;
  logic [SHAMT_W-1:0] shamt;

  assign sel   = alu_sel_t'(SEL);
  assign shamt = op2[SHAMT_W-1:0];

  always_comb begin
    bad = '0;
    for (int i = 0; i < WIDTH; i++) bad[i] = ALU_BAD_PATTERN[i % 32];
  end

  always_comb begin
    base_res = bad;
    case (sel)
      SEL_ADD:  base_res = op1 + op2;
      SEL_SUB:  base_res = op1 - op2;
      SEL_SLL:  base_res = op1 << shamt;
      SEL_SRL:  base_res = op1 >> shamt;
      SEL_SRA:  base_res = $signed(op1) >>> shamt;
      SEL_SLT:  base_res = {{(WIDTH-1){1'b0}}, $signed(op1) < $signed(op2)};
      SEL_SLTU: base_res = {{(WIDTH-1){1'b0}}, op1 < op2};
      SEL_XOR:  base_res = op1 ^ op2;
      SEL_OR:   base_res = op1 | op2;
      SEL_AND:  base_res = op1 & op2;
      SEL_LUI:  base_res = op1;
      default:  base_res = bad;
    endcase
  end

`ifdef ALU_MDU_EN
  logic             mdu_start, mdu_done, div_zero, div_ovf, special;
  logic [WIDTH-1:0] mdu_res, spec_res;

  // divide-by-zero and signed overflow bypass the iteration
  assign div_zero = (op2 == '0);
  assign div_ovf  = !SEL[0] && (op1 == {1'b1, {(WIDTH-1){1'b0}}}) && (op2 == '1);
  assign special  = SEL[2] && (div_zero || div_ovf);
  assign spec_res = div_zero ? (SEL[1] ? op1 : '1) : (SEL[1] ? '0 : op1);

  iter_muldiv #(.WIDTH(WIDTH)) u_mdu (
    .clk   (CLK),
    .rst_n (RST_N),
    .start (mdu_start),
    .op    (SEL[2:0]),
    .a     (op1),
    .b     (op2),
    .done  (mdu_done),
    .res   (mdu_res)
  );
`endif

  always_comb begin
    nxt_state  = state;
    nxt_result = result;
`ifdef ALU_MDU_EN
    mdu_start  = 1'b0;
`endif
    case (state)
      IDLE: if (in_valid) begin
        nxt_state  = DONE;
        nxt_result = base_res;
`ifdef ALU_MDU_EN
        if (SEL[4]) begin
          if (special) nxt_result = spec_res;
          else begin
            nxt_result = result;
            nxt_state  = ITER;
            mdu_start  = 1'b1;
          end
        end
`endif
      end
`ifdef ALU_MDU_EN
      ITER: if (mdu_done) nxt_state = FIX;
      FIX: begin
        nxt_result = mdu_res;
        nxt_state  = DONE;
      end
`endif
      DONE: if (out_ready) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state  <= IDLE;
      result <= '0;
    end else begin
      state  <= nxt_state;
      result <= nxt_result;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
`ifdef ALU_MDU_EN
  assign busy = (state == ITER) || (state == FIX);
`else
  assign busy = 1'b0;
`endif

endmodule
